// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_pkg;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;

  // Round-robin successor of a granted index.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: producers (master) present requests, the arbiter (slave) acknowledges.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = rf_wb_pkg::NUM_REQ,
    parameter int ADDR_W  = rf_wb_pkg::ADDR_W,
    parameter int DATA_W  = rf_wb_pkg::DATA_W
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = rf_wb_pkg::NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);
    always_comb begin
        logic        found;
        int unsigned idx;
        found   = 1'b0;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (32'(rr_ptr) + 32'(off)) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found               = 1'b1;
                gnt[IDX_W'(idx)]    = 1'b1;
                gnt_idx             = IDX_W'(idx);
            end
        end
    end

    assign gnt_vld = |req;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file's single write port from registers.
// Optional pending-write scoreboard for RAW stalls is enabled by defining RF_WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = rf_wb_pkg::NUM_REQ,
    parameter int DATA_W  = rf_wb_pkg::DATA_W,
    parameter int ADDR_W  = rf_wb_pkg::ADDR_W,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     async_reset,
    regfile_wb_arbiter_if.slave      bus,
    output logic                     rf_write_enable,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic [IDX_W-1:0]         grant_id,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_mask
);
    import rf_wb_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    logic [IDX_W-1:0]   rr_ptr_p1;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [IDX_W-1:0]   gid_p1;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr_p1),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (xfer)
    );

    assign bus.req_ready = gnt;
    assign sel_addr      = bus.req_addr[gnt_idx];
    assign sel_data      = bus.req_data[gnt_idx];

    // Stage p1: registered write port; x0 writes are acknowledged but never enabled.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            gid_p1    <= '0;
            rr_ptr_p1 <= '0;
        end else if (xfer) begin
            vld_p1    <= (sel_addr != '0);
            addr_p1   <= sel_addr;
            data_p1   <= sel_data;
            gid_p1    <= gnt_idx;
            rr_ptr_p1 <= IDX_W'(rr_next(32'(gnt_idx), NUM_REQ));
        end else begin
            vld_p1    <= 1'b0;
        end
    end

    assign rf_write_enable = vld_p1;
    assign rf_write_addr   = addr_p1;
    assign rf_write_data   = data_p1;
    assign grant_id        = gid_p1;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREG-1:0] pending_p1;
    logic [NREG-1:0] pending_nxt;

    // Set is applied after clear so a newly issued producer stays pending.
    always_comb begin
        pending_nxt = pending_p1;
        if (xfer && sel_addr != '0)
            pending_nxt = pending_nxt & ~(NREG'(1) << sel_addr);
        if (issue_valid && issue_addr != '0)
            pending_nxt = pending_nxt | (NREG'(1) << issue_addr);
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset)
            pending_p1 <= '0;
        else
            pending_p1 <= pending_nxt;
    end

    assign busy_mask = pending_p1;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_addr};
    assign busy_mask    = '0;
`endif
endmodule
